// File: rtl/pe_pkg.sv
// pe_pkg: shared mode constants, lane slicing and wrap/saturating add for the weight-stationary PE.
package pe_pkg;
  localparam logic ACC_SYSTOLIC = 1'b0;
  localparam logic ACC_LOCAL = 1'b1;
  localparam int MAX_W = 64;
  function automatic int lane_lsb(input int i, input int w);
    return i * w;
  endfunction
  // Operands arrive sign-extended to MAX_W; the result is meaningful in its low w bits.
  function automatic logic [MAX_W-1:0] add_sat(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                               input int w, input logic sat);
    logic signed [MAX_W:0] s, hi, lo;
    s = $signed({a[MAX_W-1], a}) + $signed({b[MAX_W-1], b});
    hi = $signed(({{MAX_W{1'b0}}, 1'b1} << (w - 1)) - {{MAX_W{1'b0}}, 1'b1});
    lo = ~hi;
    if (!sat) return s[MAX_W-1:0];
    return s > hi ? hi[MAX_W-1:0] : s < lo ? lo[MAX_W-1:0] : s[MAX_W-1:0];
  endfunction
endpackage

// File: rtl/pe_mac_ws_lane.sv
// pe_lane: one lane's double-buffered weight, multiply, add/saturate and local accumulator.
module pe_lane import pe_pkg::*; #(
  parameter int D_W = 64,
  parameter int A_W = 16,
  parameter int W_W = 16,
  parameter int SAT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           acc_mode,
  input  logic           acc_clear,
  input  logic           drain,
  input  logic           w_load,
  input  logic           w_swap,
  input  logic [W_W-1:0] w_data,
  input  logic           v1,
  input  logic [A_W-1:0] act,
  input  logic [D_W-1:0] psum,
  output logic [D_W-1:0] out_psum
);
  logic [W_W-1:0] w_sh, w_act;
  logic [D_W-1:0] acc, prod, sys_sum, acc_sum;
  logic signed [A_W+W_W-1:0] prod_full;
  assign prod_full = $signed(act) * $signed(w_act);
  assign prod = D_W'(prod_full);
  assign sys_sum = D_W'(add_sat(MAX_W'($signed(psum)), MAX_W'($signed(prod)), D_W, SAT != 0));
  assign acc_sum = D_W'(add_sat(MAX_W'($signed(acc)), MAX_W'($signed(prod)), D_W, SAT != 0));
  // Swap reads the pre-edge shadow, so load+swap together moves the old shadow to active.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_sh <= '0;
      w_act <= '0;
      acc <= '0;
      out_psum <= '0;
    end else begin
      if (w_load) w_sh <= w_data;
      if (w_swap) w_act <= w_sh;
      if (en && acc_mode == ACC_SYSTOLIC && v1) out_psum <= sys_sum;
      if (en && acc_mode == ACC_LOCAL) begin
        if (drain) out_psum <= acc;
        if (acc_clear) acc <= v1 ? prod : '0;
        else if (v1) acc <= acc_sum;
      end
    end
endmodule

// File: rtl/pe_mac_ws.sv
// pe_mac_ws: N_LANE weight-stationary MAC lanes sharing a broadcast activation, with east forwarding.
module pe_mac_ws import pe_pkg::*; #(
  parameter int D_W = 64,
  parameter int A_W = 16,
  parameter int W_W = 16,
  parameter int N_LANE = 4,
  parameter int SAT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  acc_mode,
  input  logic                  acc_clear,
  input  logic                  drain,
  input  logic                  w_load,
  input  logic [N_LANE*W_W-1:0] w_data,
  input  logic                  w_swap,
  input  logic                  in_valid,
  input  logic [A_W-1:0]        in_act,
  input  logic [N_LANE*D_W-1:0] in_psum,
  output logic [A_W-1:0]        act_out,
  output logic                  act_valid_out,
  output logic                  out_valid,
  output logic [N_LANE*D_W-1:0] out_psum
);
  logic [N_LANE*D_W-1:0] psum1;
  // The stage-1 activation and valid registers are exactly what is forwarded east.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act_out <= '0;
      act_valid_out <= 1'b0;
      psum1 <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      act_out <= in_act;
      act_valid_out <= in_valid;
      psum1 <= in_psum;
      out_valid <= (acc_mode == ACC_LOCAL) ? drain : act_valid_out;
    end
  for (genvar i = 0; i < N_LANE; i++) begin : g_lane
    pe_lane #(.D_W(D_W), .A_W(A_W), .W_W(W_W), .SAT(SAT)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .acc_mode(acc_mode),
      .acc_clear(acc_clear),
      .drain(drain),
      .w_load(w_load),
      .w_swap(w_swap),
      .w_data(w_data[lane_lsb(i, W_W) +: W_W]),
      .v1(act_valid_out),
      .act(act_out),
      .psum(psum1[lane_lsb(i, D_W) +: D_W]),
      .out_psum(out_psum[lane_lsb(i, D_W) +: D_W])
    );
  end
endmodule

// File: tb/tb_pe_mac_ws.sv
// tb_pe_mac_ws: directed vectors, corner sequences and a randomized run against a behavioural model.
module tb_pe_mac_ws;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, en, acc_mode, acc_clear, drain, w_load, w_swap, in_valid;
  logic [63:0] w_data;
  logic [15:0] in_act, w16, p16;
  logic [255:0] in_psum, out_psum;
  logic [15:0] act_out, ao_w, ao_s, op_w, op_s;
  logic act_valid_out, out_valid, avo_w, avo_s, ov_w, ov_s;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  pe_mac_ws dut (
    .clk(clk), .rst_n(rst_n), .en(en), .acc_mode(acc_mode), .acc_clear(acc_clear), .drain(drain),
    .w_load(w_load), .w_data(w_data), .w_swap(w_swap), .in_valid(in_valid), .in_act(in_act),
    .in_psum(in_psum), .act_out(act_out), .act_valid_out(act_valid_out), .out_valid(out_valid),
    .out_psum(out_psum));
  pe_mac_ws #(.D_W(16), .N_LANE(1), .SAT(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .acc_mode(acc_mode), .acc_clear(acc_clear), .drain(drain),
    .w_load(w_load), .w_data(w16), .w_swap(w_swap), .in_valid(in_valid), .in_act(in_act),
    .in_psum(p16), .act_out(ao_w), .act_valid_out(avo_w), .out_valid(ov_w), .out_psum(op_w));
  pe_mac_ws #(.D_W(16), .N_LANE(1), .SAT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .acc_mode(acc_mode), .acc_clear(acc_clear), .drain(drain),
    .w_load(w_load), .w_data(w16), .w_swap(w_swap), .in_valid(in_valid), .in_act(in_act),
    .in_psum(p16), .act_out(ao_s), .act_valid_out(avo_s), .out_valid(ov_s), .out_psum(op_s));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Behavioural model: 64-bit wrap arithmetic on integer arrays, one update per clock edge.
  longint m_sh[4], m_ac[4], m_p1[4], m_op[4], m_acc[4], prod[4];
  logic m_v1, m_ov;
  logic [15:0] m_a1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_sh[i] = 0; m_ac[i] = 0; m_p1[i] = 0; m_op[i] = 0; m_acc[i] = 0;
      end
      m_v1 = 0; m_ov = 0; m_a1 = 0;
    end else begin
      for (int i = 0; i < 4; i++) prod[i] = longint'($signed(m_a1)) * m_ac[i];
      if (en) begin
        if (!acc_mode) begin
          for (int i = 0; i < 4; i++) if (m_v1) m_op[i] = m_p1[i] + prod[i];
          m_ov = m_v1;
        end else begin
          m_ov = drain;
          for (int i = 0; i < 4; i++) begin
            if (drain) m_op[i] = m_acc[i];
            if (acc_clear) m_acc[i] = m_v1 ? prod[i] : 0;
            else if (m_v1) m_acc[i] = m_acc[i] + prod[i];
          end
        end
        m_v1 = in_valid;
        m_a1 = in_act;
        for (int i = 0; i < 4; i++) m_p1[i] = in_psum[i*64 +: 64];
      end
      for (int i = 0; i < 4; i++) begin
        if (w_swap) m_ac[i] = m_sh[i];
        if (w_load) m_sh[i] = longint'($signed(w_data[i*16 +: 16]));
      end
    end

  always @(negedge clk)
    if (rst_n && chk_en) begin
      chk("model act_out", 64'(act_out), 64'(m_a1));
      chk("model act_valid_out", 64'(act_valid_out), 64'(m_v1));
      chk("model out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) for (int i = 0; i < 4; i++) chk("model out_psum", out_psum[i*64 +: 64], m_op[i]);
    end

  typedef struct packed {
    logic [63:0] w;
    logic [15:0] act;
    logic [255:0] psum;
    logic [255:0] exp;
  } vec_t;
  vec_t tbl[4];

  task automatic tick();
    @(negedge clk);
  endtask
  task automatic load_w(input logic [63:0] w);
    w_data = w; w_load = 1; tick(); w_load = 0; w_swap = 1; tick(); w_swap = 0;
  endtask
  task automatic inject(input logic [15:0] a, input logic [255:0] p);
    in_act = a; in_psum = p; in_valid = 1; tick(); in_valid = 0;
  endtask
  task automatic chk_all(input string nm, input logic [63:0] v);
    for (int i = 0; i < 4; i++) chk(nm, out_psum[i*64 +: 64], v);
  endtask

  initial begin
    tbl[0] = '{w: {16'(-1), 16'(3), 16'(2), 16'(1)}, act: 16'(5), psum: {4{64'(10)}},
               exp: {64'(5), 64'(25), 64'(20), 64'(15)}};
    tbl[1] = '{w: {16'(32767), 16'(0), 16'(-4), 16'(4)}, act: 16'(-3),
               psum: {64'(1), 64'(-7), 64'(100), 64'(0)},
               exp: {64'(-98300), 64'(-7), 64'(112), 64'(-12)}};
    tbl[2] = '{w: {16'(0), 16'(1), 16'(32767), 16'h8000}, act: 16'h8000,
               psum: {64'(5), 64'(-1), 64'(0), 64'(0)},
               exp: {64'(5), 64'(-32769), 64'(-1073709056), 64'(1073741824)}};
    tbl[3] = '{w: {16'(2), 16'(-1), 16'(1), 16'(1)}, act: 16'(1),
               psum: {64'(-3), 64'h8000_0000_0000_0000, 64'(0), 64'h7fff_ffff_ffff_ffff},
               exp: {64'(-1), 64'h7fff_ffff_ffff_ffff, 64'(1), 64'h8000_0000_0000_0000}};
    rst_n = 0; en = 1; acc_mode = 0; acc_clear = 0; drain = 0; w_load = 0; w_swap = 0;
    in_valid = 0; w_data = 0; in_act = 0; in_psum = 0; w16 = 0; p16 = 0;
    repeat (2) tick();
    chk("reset out_valid", 64'(out_valid), 0);
    chk("reset act_valid_out", 64'(act_valid_out), 0);
    chk("reset out_psum", out_psum[63:0], 0);
    rst_n = 1; chk_en = 1; tick();
    for (int k = 0; k < 4; k++) begin
      load_w(tbl[k].w);
      inject(tbl[k].act, tbl[k].psum);
      chk("vec act_out", 64'(act_out), 64'(tbl[k].act));
      chk("vec act_valid_out", 64'(act_valid_out), 1);
      chk("vec early out_valid", 64'(out_valid), 0);
      tick();
      chk("vec out_valid", 64'(out_valid), 1);
      for (int i = 0; i < 4; i++) chk("vec out_psum", out_psum[i*64 +: 64], tbl[k].exp[i*64 +: 64]);
      tick();
      chk("vec out_valid drop", 64'(out_valid), 0);
    end
    // Stall with data in stage 1, then stall with a result held on the output.
    load_w(tbl[0].w);
    inject(16'(5), {4{64'(10)}});
    en = 0;
    repeat (3) begin tick(); chk("stall no out_valid", 64'(out_valid), 0); end
    en = 1; tick();
    chk("stall out_valid", 64'(out_valid), 1);
    chk("stall lane3", out_psum[255:192], 64'(5));
    en = 0;
    repeat (3) begin
      tick();
      chk("hold out_valid", 64'(out_valid), 1);
      chk("hold lane0", out_psum[63:0], 64'(15));
    end
    en = 1; tick();
    chk("unstall out_valid", 64'(out_valid), 0);
    // Double buffer: load+swap together promotes the old shadow (2), not 7.
    load_w({4{16'(2)}});
    w_data = {4{16'(7)}}; w_load = 1; w_swap = 1;
    inject(16'(3), '0);
    w_load = 0; w_swap = 0; tick();
    chk_all("dbuf old shadow", 64'(6));
    w_swap = 1; tick(); w_swap = 0;
    inject(16'(3), '0); tick();
    chk_all("dbuf swap", 64'(21));
    w_data = {4{16'(1)}}; w_load = 1; tick(); w_load = 0;
    inject(16'(3), '0);
    w_swap = 1; tick(); w_swap = 0;
    chk_all("dbuf in-flight", 64'(21));
    inject(16'(3), '0); tick();
    chk_all("dbuf new active", 64'(3));
    // Local accumulation.
    load_w({4{16'(3)}});
    acc_mode = 1; acc_clear = 1; tick(); acc_clear = 0;
    for (int a = 1; a <= 4; a++) begin in_act = 16'(a); in_valid = 1; tick(); end
    in_valid = 0; tick();
    drain = 1; tick(); drain = 0;
    chk("acc drain valid", 64'(out_valid), 1);
    chk_all("acc drain", 64'(30));
    tick();
    chk("acc single pulse", 64'(out_valid), 0);
    drain = 1; acc_clear = 1; tick(); acc_clear = 0;
    chk_all("acc drain+clear", 64'(30));
    tick(); drain = 0;
    chk_all("acc after clear", 64'(0));
    in_act = 16'(2); in_valid = 1; tick(); in_valid = 0; acc_clear = 1; tick(); acc_clear = 0;
    in_act = 16'(5); in_valid = 1; tick(); in_valid = 0; tick();
    drain = 1; tick(); drain = 0;
    chk_all("acc clear+add", 64'(21));
    tick(); acc_mode = 0;
    // 16-bit overflow: wrap vs saturate.
    w16 = 16'(1); load_w({4{16'(1)}});
    p16 = 16'h7fff; inject(16'(1), '0); tick();
    chk("ovf wrap valid", 64'(ov_w), 1);
    chk("ovf wrap pos", 64'(op_w), 64'h8000);
    chk("ovf sat pos", 64'(op_s), 64'h7fff);
    p16 = 16'h8000; inject(16'hffff, '0); tick();
    chk("ovf wrap neg", 64'(op_w), 64'h7fff);
    chk("ovf sat neg", 64'(op_s), 64'h8000);
    // Asynchronous reset with a transaction in stage 1.
    inject(16'(9), '0);
    #2 rst_n = 0;
    #1;
    chk("areset out_valid", 64'(out_valid), 0);
    chk("areset act_valid_out", 64'(act_valid_out), 0);
    chk("areset act_out", 64'(act_out), 0);
    chk("areset out_psum", out_psum[63:0], 0);
    tick(); tick(); rst_n = 1;
    repeat (3) begin tick(); chk("areset no out_valid", 64'(out_valid), 0); end
    // Randomized runs in each mode, pipeline flushed before a mode change.
    for (int m = 0; m < 2; m++) begin
      acc_mode = m[0];
      for (int c = 0; c < 400; c++) begin
        en = ($urandom % 5) != 0;
        in_valid = $urandom % 2;
        in_act = 16'($urandom);
        for (int i = 0; i < 8; i++) in_psum[i*32 +: 32] = $urandom;
        w_data = {$urandom, $urandom};
        w_load = ($urandom % 4) == 0;
        w_swap = ($urandom % 6) == 0;
        acc_clear = m == 1 && ($urandom % 8) == 0;
        drain = m == 1 && ($urandom % 5) == 0;
        tick();
      end
      en = 1; in_valid = 0; w_load = 0; w_swap = 0; acc_clear = 0; drain = 0;
      repeat (2) tick();
    end
    acc_mode = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
